pwm_speed_ramp: RTL and testbench
=================================

// Module: pwm_speed_ramp
// PURPOSE
//  Slew-rate limiter upstream of the PWM speed stage. Accepts target speed commands
//  (0..255) over a valid/ready handshake and clips them to MAX_SPEED. Ramps the 8-bit
//  speed_out toward the target by STEP once every TICK_DIV clocks. speed_out drives
//  the PWM stage data_in. estop forces speed to 0 immediately.
// PARAMETERS
//  MAX_SPEED  200   highest legal speed; larger commands are clipped to this value
//  STEP       1     speed increment/decrement per ramp tick (1..255)
//  TICK_DIV   1000  clocks per ramp tick (>=1); tick counter width = $clog2(TICK_DIV)+1
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  synchronous, active-low reset
//  cmd_valid  in   1  cmd_speed valid
//  cmd_ready  out  1  block accepts a command this cycle
//  cmd_speed  in   8  requested speed
//  estop      in   1  emergency stop, level-sensitive, highest priority after rst
//  speed_out  out  8  ramped speed to PWM stage (registered)
//  cmd_clip   out  1  1-cycle pulse: last accepted command was > MAX_SPEED
//  at_target  out  1  speed_out == target and state IDLE
//  busy       out  1  state is UP or DOWN
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, speed_out=0, target_q=0, tick_cnt=0,
//   cmd_clip=0. At_target=1 and busy=0 follow from state. cmd_ready=0 while rst==0.
//  cmd_ready = rst && !estop && state!=STOP (combinational). Accept on valid&&ready.
//  Accept edge: target_q <= min(cmd_speed, MAX_SPEED); cmd_clip <= (cmd_speed>MAX_SPEED).
//   State is set the same edge from the new target vs speed_out: > UP, < DOWN, == IDLE.
//   busy is therefore 1 on the cycle after the accept.
//  States: IDLE, UP, DOWN, STOP.
//   IDLE: tick_cnt held at 0. Leaves IDLE only on accept or estop.
//   UP/DOWN: tick_cnt increments each clock and wraps at TICK_DIV-1. On the wrap cycle
//    speed_out steps: UP -> min(speed_out+STEP, target_q); DOWN -> max(speed_out-STEP,
//    target_q). Compute in 9 bits; no overflow or underflow past target.
//    The step that lands on target_q also moves the state to IDLE and clears tick_cnt.
//   First step is TICK_DIV clocks after the accept edge.
//   Retarget mid-ramp: new command accepted in UP/DOWN updates target_q. Direction is
//    re-evaluated on the same edge (UP<->DOWN, or IDLE if equal). tick_cnt is not
//    cleared, so cadence continues.
//   STOP: entered on any clock with estop==1 (from any state). Same edge:
//    speed_out<=0, target_q<=0, tick_cnt<=0. A cmd_valid in that cycle is not accepted.
//    Stays in STOP while estop==1. The first clock with estop==0 -> IDLE.
//  Priority: rst > estop > accept > tick step.
//  A command equal to speed_out while IDLE: accepted, stays IDLE, no tick.
//  Reset mid-ramp: full reset values next edge; ramp abandoned.
//  cmd_clip deasserts the cycle after its pulse unless another clipped command is accepted.
// TESTING
//  T1 reset: rst=0 for 3 clks -> speed_out=0, at_target=1, busy=0, cmd_ready=0;
//     rst=1 -> cmd_ready=1.
//  T2 ramp up (TICK_DIV=4, STEP=1): cmd 5 from 0 -> speed_out +1 every 4 clks;
//     5 reached 20 clks after accept, then at_target=1, busy=0.
//  T3 clip: cmd 250 -> cmd_clip pulses 1 clk, target_q=200; speed_out stops at 200.
//  T4 ramp down (STEP=3): speed 10, cmd 0 -> 7,4,1,0 on successive ticks; never wraps.
//  T5 retarget: ramping to 100, at speed 40 cmd 20 -> state DOWN on accept edge;
//     next step is to 39 on the original cadence; settles at 20.
//  T6 estop: mid-ramp at 60, estop=1 with cmd_valid=1 -> speed_out=0 next clk, cmd not
//     accepted, cmd_ready=0; estop=0 -> IDLE, at_target=1, cmd_ready=1.

Source files
------------

// File: rtl/pwm_speed_ramp_if.sv
// Command channel into the speed ramp: target speed offered over valid/ready.
interface pwm_speed_ramp_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_speed;

  modport master (output cmd_valid, output cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/pwm_speed_ramp.sv
// Slew-rate limiter feeding the PWM stage: ramps speed_out toward a clipped target
// by STEP every TICK_DIV clocks; estop zeroes everything at once.
module pwm_speed_ramp #(
  parameter int MAX_SPEED = 200,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  pwm_speed_ramp_if.slave     cmd,
  input  logic                estop,
  output logic [7:0]          speed_out,
  output logic                cmd_clip,
  output logic                at_target,
  output logic                busy
);

  localparam int                 CW        = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0]      TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [8:0]         STEP9     = 9'(STEP);
  localparam logic [7:0]         MAX8      = 8'(MAX_SPEED);

  typedef enum logic [1:0] {IDLE, UP, DOWN, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    speed_q, speed_d;
  logic [7:0]    target_q, target_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          clip_q, clip_d;

  logic          accept;
  logic          wrap;
  logic [7:0]    cmd_tgt;
  logic [8:0]    up_sum;
  logic [8:0]    dn_diff;
  logic [7:0]    up_next;
  logic [7:0]    dn_next;
  logic [7:0]    step_next;

  function automatic state_e dir_of(input logic [7:0] tgt, input logic [7:0] spd);
    if (tgt > spd)      return UP;
    else if (tgt < spd) return DOWN;
    else                return IDLE;
  endfunction

  assign cmd.cmd_ready = rst && !estop && (state_q != STOP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_tgt       = (cmd.cmd_speed > MAX8) ? MAX8 : cmd.cmd_speed;
  assign wrap          = (tick_q == TICK_LAST);

  // 9-bit arithmetic so a step can never wrap past the target in either direction.
  assign up_sum    = {1'b0, speed_q} + STEP9;
  assign dn_diff   = {1'b0, speed_q} - STEP9;
  assign up_next   = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
  assign dn_next   = (dn_diff[8] || (dn_diff[7:0] <= target_q)) ? target_q : dn_diff[7:0];
  assign step_next = (state_q == UP) ? up_next : dn_next;

  // NOTE: every variable gets its default before any branch, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    target_d = target_q;
    tick_d   = tick_q;
    clip_d   = 1'b0;

    if (estop) begin
      state_d  = STOP;
      speed_d  = '0;
      target_d = '0;
      tick_d   = '0;
    end else begin
      case (state_q)
        STOP: begin
          state_d = IDLE;
          tick_d  = '0;
        end
        IDLE: begin
          tick_d = '0;
          if (accept) begin
            target_d = cmd_tgt;
            clip_d   = (cmd.cmd_speed > MAX8);
            state_d  = dir_of(cmd_tgt, speed_q);
          end
        end
        UP, DOWN: begin
          tick_d = wrap ? '0 : tick_q + CW'(1);
          // A retarget on a wrap cycle takes precedence; that tick's step is skipped.
          if (accept) begin
            target_d = cmd_tgt;
            clip_d   = (cmd.cmd_speed > MAX8);
            state_d  = dir_of(cmd_tgt, speed_q);
          end else if (wrap) begin
            speed_d = step_next;
            if (step_next == target_q) state_d = IDLE;
          end
          if (state_d == IDLE) tick_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      speed_q  <= '0;
      target_q <= '0;
      tick_q   <= '0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
      tick_q   <= tick_d;
      clip_q   <= clip_d;
    end
  end

  assign speed_out = speed_q;
  assign cmd_clip  = clip_q;
  assign at_target = (state_q == IDLE) && (speed_q == target_q);
  assign busy      = (state_q == UP) || (state_q == DOWN);

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// Two ramp instances (STEP 1 and 3) share one stimulus stream and are compared each
// cycle against a cadence-based model; a few literal expectations pin that model.
module tb_pwm_speed_ramp;

  localparam int TD   = 4;
  localparam int MAXS = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       estop;
  logic       cmd_valid;
  logic [7:0] cmd_speed;

  logic [7:0] so [2];
  logic       clip_o [2];
  logic       at_o [2];
  logic       busy_o [2];
  logic       rdy_o [2];

  always #5 clk = ~clk;

  pwm_speed_ramp_if if0 ();
  pwm_speed_ramp_if if1 ();

  assign if0.cmd_valid = cmd_valid;
  assign if0.cmd_speed = cmd_speed;
  assign if1.cmd_valid = cmd_valid;
  assign if1.cmd_speed = cmd_speed;
  assign rdy_o[0]      = if0.cmd_ready;
  assign rdy_o[1]      = if1.cmd_ready;

  pwm_speed_ramp #(.MAX_SPEED(MAXS), .STEP(1), .TICK_DIV(TD)) u0 (
    .clk(clk), .rst(rst), .cmd(if0.slave), .estop(estop),
    .speed_out(so[0]), .cmd_clip(clip_o[0]), .at_target(at_o[0]), .busy(busy_o[0])
  );

  pwm_speed_ramp #(.MAX_SPEED(MAXS), .STEP(3), .TICK_DIV(TD)) u1 (
    .clk(clk), .rst(rst), .cmd(if1.slave), .estop(estop),
    .speed_out(so[1]), .cmd_clip(clip_o[1]), .at_target(at_o[1]), .busy(busy_o[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an instance is ramping whenever speed != target; steps land on edges that
  // are a whole number of TD periods after the edge that started the ramp.
  int m_speed [2];
  int m_target [2];
  int m_start [2];
  bit m_stop [2];
  bit m_clip [2];
  int edge_n = 0;

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_speed[i] = 0; m_target[i] = 0; m_start[i] = 0; m_stop[i] = 0; m_clip[i] = 0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        m_clip[i] = 1'b0;
        if (!rst) begin
          m_speed[i] = 0; m_target[i] = 0; m_stop[i] = 1'b0;
        end else if (estop) begin
          m_speed[i] = 0; m_target[i] = 0; m_stop[i] = 1'b1;
        end else if (m_stop[i]) begin
          m_stop[i] = 1'b0;
        end else if (cmd_valid) begin
          if (m_speed[i] == m_target[i]) m_start[i] = edge_n;
          m_target[i] = (int'(cmd_speed) > MAXS) ? MAXS : int'(cmd_speed);
          m_clip[i]   = (int'(cmd_speed) > MAXS);
        end else if (m_speed[i] != m_target[i] && ((edge_n - m_start[i]) % TD) == 0) begin
          if (m_target[i] > m_speed[i])
            m_speed[i] = (m_speed[i] + step_of(i) > m_target[i]) ? m_target[i] : m_speed[i] + step_of(i);
          else
            m_speed[i] = (m_speed[i] - step_of(i) < m_target[i]) ? m_target[i] : m_speed[i] - step_of(i);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("u%0d_speed", i), int'(so[i]), m_speed[i]);
          check($sformatf("u%0d_ready", i), int'(rdy_o[i]), int'(rst && !estop && !m_stop[i]));
          check($sformatf("u%0d_clip", i), int'(clip_o[i]), int'(m_clip[i]));
          check($sformatf("u%0d_at_target", i), int'(at_o[i]),
                int'(!m_stop[i] && m_speed[i] == m_target[i]));
          check($sformatf("u%0d_busy", i), int'(busy_o[i]),
                int'(!m_stop[i] && m_speed[i] != m_target[i]));
        end
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v);
    cmd_valid = 1'b1;
    cmd_speed = 8'(v);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int dn_exp [4];
    dn_exp = '{7, 4, 1, 0};
    rst = 1'b0; estop = 1'b0; cmd_valid = 1'b0; cmd_speed = '0;

    // Reset state
    adv(3);
    chk_en = 1'b1;
    check("t1_speed", int'(so[0]), 0);
    check("t1_at_target", int'(at_o[0]), 1);
    check("t1_busy", int'(busy_o[0]), 0);
    check("t1_ready_in_reset", int'(rdy_o[0]), 0);
    rst = 1'b1;
    #1;
    check("t1_ready_after", int'(rdy_o[0]), 1);
    adv(1);

    // Ramp up 0 -> 5 with STEP 1: five ticks of four clocks
    send(5);
    adv(19);
    check("t2_speed_19", int'(so[0]), 4);
    check("t2_busy_19", int'(busy_o[0]), 1);
    adv(1);
    check("t2_speed_20", int'(so[0]), 5);
    check("t2_at_target", int'(at_o[0]), 1);
    check("t2_busy_20", int'(busy_o[0]), 0);

    // Ramp down 10 -> 0 with STEP 3: 7, 4, 1, 0
    adv(2);
    send(10);
    adv(10);
    check("t4_start", int'(so[1]), 10);
    send(0);
    for (int k = 0; k < 4; k++) begin
      adv(4);
      check($sformatf("t4_down_%0d", k), int'(so[1]), dn_exp[k]);
    end
    adv(4);
    check("t4_hold", int'(so[1]), 0);
    check("t4_at_target", int'(at_o[1]), 1);

    // Emergency stop mid-ramp at 60 with a command offered
    adv(40);
    send(100);
    adv(240);
    check("t6_speed_60", int'(so[0]), 60);
    estop = 1'b1; cmd_valid = 1'b1; cmd_speed = 8'd150;
    #1;
    check("t6_ready_estop", int'(rdy_o[0]), 0);
    adv(1);
    check("t6_speed0_u0", int'(so[0]), 0);
    check("t6_speed0_u1", int'(so[1]), 0);
    check("t6_at_target_stop", int'(at_o[0]), 0);
    adv(2);
    estop = 1'b0; cmd_valid = 1'b0;
    adv(1);
    check("t6_at_target_idle", int'(at_o[0]), 1);
    check("t6_ready_idle", int'(rdy_o[0]), 1);

    // Retarget from UP to DOWN at 40; cadence continues
    send(100);
    adv(160);
    check("t5_speed_40", int'(so[0]), 40);
    send(20);
    check("t5_busy", int'(busy_o[0]), 1);
    check("t5_hold_40", int'(so[0]), 40);
    adv(2);
    check("t5_still_40", int'(so[0]), 40);
    adv(1);
    check("t5_step_39", int'(so[0]), 39);
    adv(100);
    check("t5_settle_20", int'(so[0]), 20);
    check("t5_at_target", int'(at_o[0]), 1);

    // Clipped command
    send(250);
    check("t3_clip_pulse", int'(clip_o[0]), 1);
    adv(1);
    check("t3_clip_drop", int'(clip_o[0]), 0);
    adv(760);
    check("t3_top_u0", int'(so[0]), 200);
    check("t3_top_u1", int'(so[1]), 200);

    // Randomised traffic: commands, estop bursts and occasional reset pulses
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 15) == 0);
      cmd_speed = 8'($urandom_range(0, 255));
      if (estop) estop = ($urandom_range(0, 2) != 0);
      else       estop = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 799) != 0);
      adv(1);
    end
    cmd_valid = 1'b0; estop = 1'b0; rst = 1'b1;
    adv(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
